divider_ctrl: RTL and testbench
===============================

# divider_ctrl

Request-side controller for the iterative unsigned divider in the M-extension datapath. Accepts DIV/DIVU/REM/REMU ops from the execute stage and resolves the RISC-V special cases locally. It converts signed operands to magnitudes, drives the divider's load/resp handshake, and applies sign correction before returning a tagged 32-bit result.

## Interface
- No parameters; widths are fixed at XLEN=32.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high; shared with the divider.
- req_valid  in  1  op request.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_rs1, req_rs2  in  32  dividend, divisor.
- req_tag  in  5  destination tag, returned unchanged.
- flush  in  1  kill the in-flight op.
- resp_valid  out  1  one-cycle result pulse; no backpressure.
- resp_result  out  32  final result.
- resp_tag  out  5  tag of the result.
- div_load  out  1  one-cycle start pulse to the divider.
- div_dividend, div_divisor  out  32  unsigned magnitudes; held stable from div_load until div_resp.
- div_quotient, div_remainder  in  32  valid only while div_resp=1.
- div_resp  in  1  divider completion pulse.

## Operation
- **Signed ops** (op[0]=0):
  - neg1=rs1[31], neg2=rs2[31].
  - Magnitudes are the two's-complement absolute values; abs(0x80000000)=0x80000000, treated as unsigned.
- **Special cases**, resolved in IDLE without touching the divider:
  - rs2==0: quotient=0xFFFFFFFF, remainder=rs1.
  - Signed op with rs1==0x80000000 and rs2==0xFFFFFFFF: quotient=0x80000000, remainder=0.
- **Sign fix**:
  - Quotient is negated iff neg1^neg2.
  - Remainder is negated iff neg1.
  - Unsigned ops pass through unchanged.
- **Result select**: op[1]=0 returns the quotient; op[1]=1 returns the remainder.
- **States**:
  - IDLE: req_ready=1. On req_valid, latch op, tag, signs and magnitudes. Special case -> RESP; else -> ISSUE.
  - ISSUE: div_load=1 -> WAIT.
  - WAIT: on div_resp, latch div_quotient/div_remainder -> FIX.
  - FIX: compute the signed result into a register -> RESP.
  - RESP: resp_valid=1 -> IDLE.
  - DRAIN: wait for div_resp, discard the result -> IDLE.
- **Flush**:
  - In ISSUE or WAIT -> DRAIN. The divider cannot be aborted.
  - In FIX or RESP: resp_valid is suppressed and the state returns to IDLE.
  - In IDLE: the request is not accepted that cycle.
- **Flush and div_resp in the same WAIT cycle**: the result is discarded -> IDLE.

## Timing
- **Reset values**: state=IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_tag=0, div_load=0, div_dividend=0, div_divisor=0.
- **Latency** (request accepted at edge of cycle N):
  - Special case: resp_valid in N+1.
  - Normal op: div_load in N+1, div_resp in N+35, resp_valid in N+37.
  - rs1==0: the divider short-cuts, giving div_resp in N+2 and resp_valid in N+4.
- resp_valid always follows div_resp by exactly 2 cycles.
- Throughput is one op in flight; req_ready=0 from N+1 until the cycle after RESP or DRAIN exit.
- Reset mid-operation resets both blocks in the same cycle; no drain is needed.

## Configuration
- **DIV_LAST_RESULT_CACHE_EN**
  - Defined: store rs1, rs2, signedness and both unsigned magnitudes of the last completed divider op, plus a valid bit.
  - A new non-special request with matching rs1/rs2/signedness goes IDLE -> FIX and skips the divider; resp_valid in N+2. This serves the DIV-then-REM idiom.
  - The valid bit clears on rst and on any flush. Drained results are never stored.
- **Undefined**: no cache storage; every non-special op goes through the divider.

## Structure
- **Package m_ext_pkg**:
  - div_op_t enum (DIV, DIVU, REM, REMU).
  - divctl_state_t enum (IDLE, ISSUE, WAIT, FIX, RESP, DRAIN).
  - Constants INT_MIN=32'h80000000 and ALL_ONES=32'hFFFFFFFF.
- **Sub-module div_sign_fix**: combinational. Takes magnitudes q/r, neg1, neg2 and op; returns the selected signed result. It is instantiated once, feeding the FIX register.

## Test plan
- DIV rs1=0xFFFFFFF9 (-7), rs2=2, tag=3 -> resp_result=0xFFFFFFFD, resp_tag=3, resp_valid at N+37; REM same operands -> 0xFFFFFFFF.
- DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU -> 1; div_dividend and div_divisor stable throughout WAIT.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both at N+1 with div_load never asserted; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Flush 10 cycles after div_load -> no resp_valid, req_ready=0 until div_resp, then 1; next DIVU 9/3 -> 3 at its own N+37.
- With DIV_LAST_RESULT_CACHE_EN: DIV 100/7 -> 14 at N+37, then REM 100/7 -> 2 at N+2 with no div_load; DIVU 100/7 after it -> full latency.

Source files
------------

// File: rtl/m_ext_pkg.sv
// m_ext_pkg: shared types and constants for the M-extension divide path.
package m_ext_pkg;

    // funct3[1:0] encoding of the divide/remainder ops
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FIX,
        RESP,
        DRAIN
    } divctl_state_t;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    // Two's-complement negation; neg32(INT_MIN) == INT_MIN, which is the
    // unsigned magnitude the divider expects.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: turns unsigned quotient/remainder magnitudes into the signed
// RISC-V result and selects quotient or remainder according to the op.
module div_sign_fix
    import m_ext_pkg::*;
(
    input  logic [31:0] q,
    input  logic [31:0] r,
    input  logic        neg1,
    input  logic        neg2,
    input  div_op_t     op,
    output logic [31:0] result
);

    logic is_signed;
    logic q_neg;
    logic r_neg;

    assign is_signed = ~op[0];
    assign q_neg     = is_signed & (neg1 ^ neg2);
    assign r_neg     = is_signed & neg1;

    // Quotient takes the xor of the operand signs, remainder takes the dividend sign.
    always_comb begin
        result = '0;
        if (op[1]) begin
            result = r_neg ? neg32(r) : r;
        end else begin
            result = q_neg ? neg32(q) : q;
        end
    end

endmodule

// File: rtl/divider_ctrl.sv
// divider_ctrl: request-side controller for the iterative unsigned divider.
// Resolves divide-by-zero and signed overflow locally, feeds the divider
// unsigned magnitudes and sign-corrects the returned quotient/remainder.
// Optional feature macro: DIV_LAST_RESULT_CACHE_EN keeps the last divider
// result so a matching follow-up request (DIV then REM) skips the divider.
//
// Handshakes: a request transfers on a clock edge where req_valid and
// req_ready are both high and flush is low; req_ready is high only in IDLE.
// resp_valid and div_load are single-cycle pulses without backpressure, and
// div_resp is a single-cycle pulse from the divider whose quotient/remainder
// are only meaningful in that cycle.
module divider_ctrl
    import m_ext_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [31:0]   req_rs1,
    input  logic [31:0]   req_rs2,
    input  logic [4:0]    req_tag,
    input  logic          flush,
    output logic          resp_valid,
    output logic [31:0]   resp_result,
    output logic [4:0]    resp_tag,
    output logic          div_load,
    output logic [31:0]   div_dividend,
    output logic [31:0]   div_divisor,
    input  logic [31:0]   div_quotient,
    input  logic [31:0]   div_remainder,
    input  logic          div_resp,
    output divctl_state_t dbg_state
);

    divctl_state_t state_q, state_d;
    div_op_t       op_q;
    logic          neg1_q, neg2_q;
    logic [31:0]   q_mag_q, r_mag_q;
    logic [31:0]   fix_result;

    logic          req_signed, req_neg1, req_neg2;
    logic [31:0]   req_mag1, req_mag2;
    logic          div_by_zero, overflow, special;
    logic [31:0]   special_result;
    logic          accept;
    logic          cache_hit;
    logic [31:0]   cache_q_mag, cache_r_mag;

    assign req_signed  = ~req_op[0];
    assign req_neg1    = req_signed & req_rs1[31];
    assign req_neg2    = req_signed & req_rs2[31];
    assign req_mag1    = req_neg1 ? neg32(req_rs1) : req_rs1;
    assign req_mag2    = req_neg2 ? neg32(req_rs2) : req_rs2;
    assign div_by_zero = (req_rs2 == 32'd0);
    assign overflow    = req_signed && (req_rs1 == INT_MIN) && (req_rs2 == ALL_ONES);
    assign special     = div_by_zero | overflow;
    // Divide-by-zero wins over overflow; its results are already final values.
    assign special_result = div_by_zero ? (req_op[1] ? req_rs1 : ALL_ONES)
                                        : (req_op[1] ? 32'd0   : INT_MIN);
    assign accept      = (state_q == IDLE) && req_valid && !flush;
    assign dbg_state   = state_q;

`ifdef DIV_LAST_RESULT_CACHE_EN
    logic        cache_valid_q, cache_signed_q;
    logic [31:0] cache_rs1_q, cache_rs2_q, cache_q_q, cache_r_q;
    logic [31:0] op_rs1_q, op_rs2_q;

    // Keep the raw operands of the in-flight op and record each completed,
    // un-flushed divider result; any flush invalidates the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid_q  <= 1'b0;
            cache_signed_q <= 1'b0;
            cache_rs1_q    <= '0;
            cache_rs2_q    <= '0;
            cache_q_q      <= '0;
            cache_r_q      <= '0;
            op_rs1_q       <= '0;
            op_rs2_q       <= '0;
        end else begin
            if (accept) begin
                op_rs1_q <= req_rs1;
                op_rs2_q <= req_rs2;
            end
            if (flush) begin
                cache_valid_q <= 1'b0;
            end else if (state_q == WAIT && div_resp) begin
                cache_valid_q  <= 1'b1;
                cache_signed_q <= ~op_q[0];
                cache_rs1_q    <= op_rs1_q;
                cache_rs2_q    <= op_rs2_q;
                cache_q_q      <= div_quotient;
                cache_r_q      <= div_remainder;
            end
        end
    end

    assign cache_hit   = cache_valid_q && (cache_rs1_q == req_rs1) &&
                         (cache_rs2_q == req_rs2) && (cache_signed_q == req_signed);
    assign cache_q_mag = cache_q_q;
    assign cache_r_mag = cache_r_q;
`else
    assign cache_hit   = 1'b0;
    assign cache_q_mag = '0;
    assign cache_r_mag = '0;
`endif

    div_sign_fix u_sign_fix (
        .q      (q_mag_q),
        .r      (r_mag_q),
        .neg1   (neg1_q),
        .neg2   (neg2_q),
        .op     (op_q),
        .result (fix_result)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs; flush after ISSUE still lets the
    // load pulse out because the divider cannot be aborted, so DRAIN waits for it.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        div_load   = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (special)        state_d = RESP;
                    else if (cache_hit) state_d = FIX;
                    else                state_d = ISSUE;
                end
            end
            ISSUE: begin
                div_load = 1'b1;
                state_d  = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (flush)         state_d = div_resp ? IDLE : DRAIN;
                else if (div_resp) state_d = FIX;
            end
            FIX: begin
                state_d = flush ? IDLE : RESP;
            end
            RESP: begin
                resp_valid = ~flush;
                state_d    = IDLE;
            end
            DRAIN: begin
                if (div_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand/result datapath: capture on accept, latch divider output, register the fixed result.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= DIV;
            neg1_q       <= 1'b0;
            neg2_q       <= 1'b0;
            q_mag_q      <= '0;
            r_mag_q      <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            resp_result  <= '0;
            resp_tag     <= '0;
        end else begin
            if (accept) begin
                op_q         <= div_op_t'(req_op);
                neg1_q       <= req_neg1;
                neg2_q       <= req_neg2;
                resp_tag     <= req_tag;
                div_dividend <= req_mag1;
                div_divisor  <= req_mag2;
                if (special) resp_result <= special_result;
                if (cache_hit) begin
                    q_mag_q <= cache_q_mag;
                    r_mag_q <= cache_r_mag;
                end
            end
            if (state_q == WAIT && div_resp) begin
                q_mag_q <= div_quotient;
                r_mag_q <= div_remainder;
            end
            if (state_q == FIX) resp_result <= fix_result;
        end
    end

endmodule

// File: tb/tb_divider_ctrl.sv
// tb_divider_ctrl: directed bench for divider_ctrl with a behavioural
// iterative divider, an expected-response queue and a decoupled monitor.
`timescale 1ns/1ps
module tb_divider_ctrl;
    import m_ext_pkg::*;

`ifdef DIV_LAST_RESULT_CACHE_EN
    localparam int HIT_LAT = 2;
`else
    localparam int HIT_LAT = 37;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [31:0]   req_rs1 = '0;
    logic [31:0]   req_rs2 = '0;
    logic [4:0]    req_tag = '0;
    logic          flush = 1'b0;
    logic          resp_valid;
    logic [31:0]   resp_result;
    logic [4:0]    resp_tag;
    logic          div_load;
    logic [31:0]   div_dividend, div_divisor;
    logic [31:0]   div_quotient = 32'hDEAD_BEEF;
    logic [31:0]   div_remainder = 32'hDEAD_BEEF;
    logic          div_resp = 1'b0;
    divctl_state_t dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    divider_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_tag       (req_tag),
        .flush         (flush),
        .resp_valid    (resp_valid),
        .resp_result   (resp_result),
        .resp_tag      (resp_tag),
        .div_load      (div_load),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_resp      (div_resp),
        .dbg_state     (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- divider model ----------------
    // 34-cycle iterative divider (1 cycle when the dividend is zero);
    // outputs change 1ns after the clock edge so they are stable at both edges.
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_dvd = '0, m_dvs = '0;
    int          load_cnt = 0;
    logic [31:0] last_dividend = '0, last_divisor = '0;

    always @(posedge clk) begin
        #1;
        div_resp      = 1'b0;
        div_quotient  = 32'hDEAD_BEEF;
        div_remainder = 32'hDEAD_BEEF;
        if (rst) begin
            m_busy = 1'b0;
        end else begin
            if (m_busy) begin
                check("div_dividend_stable", div_dividend, m_dvd);
                check("div_divisor_stable", div_divisor, m_dvs);
                m_cnt--;
                if (m_cnt == 0) begin
                    div_resp      = 1'b1;
                    div_quotient  = (m_dvs == 0) ? ALL_ONES : m_dvd / m_dvs;
                    div_remainder = (m_dvs == 0) ? m_dvd : m_dvd % m_dvs;
                    m_busy        = 1'b0;
                end
            end
            if (div_load) begin
                load_cnt++;
                m_busy        = 1'b1;
                m_dvd         = div_dividend;
                m_dvs         = div_divisor;
                last_dividend = div_dividend;
                last_divisor  = div_divisor;
                m_cnt         = (div_dividend == 0) ? 1 : 34;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [36:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [36:0] mon_e;
    int          mon_ec;

    // Monitor: every response pops one expectation (tag, result, cycle).
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=%h tag=%0d required=no_response t=%0t",
                         resp_result, resp_tag, $time);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ec = exp_cyc_q.pop_front();
                check("resp_result", resp_result, mon_e[31:0]);
                check("resp_tag", {27'd0, resp_tag}, {27'd0, mon_e[36:32]});
                check("resp_cycle", cyc, mon_ec);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_resp();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=none required=%0d_pending", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input int lat);
        int l0;
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        l0        = load_cnt;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
        req_valid = 1'b1;
        exp_q.push_back({tag, exp});
        exp_cyc_q.push_back(cyc + lat);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp();
        if (lat <= 2) check("div_load_count", load_cnt, l0);
        else          check("div_load_count", load_cnt, l0 + 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int  l0;
        logic seen;

        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_tag", {27'd0, resp_tag}, 32'd0);
        check("rst_div_load", {31'd0, div_load}, 32'd0);
        check("rst_div_dividend", div_dividend, 32'd0);
        check("rst_div_divisor", div_divisor, 32'd0);
        rst = 1'b0;

        // signed with negative dividend
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 37);
        check("mag_dividend", last_dividend, 32'd7);
        check("mag_divisor", last_divisor, 32'd2);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, HIT_LAT);
        // unsigned full-range dividend
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'h7FFF_FFFF, 37);
        check("mag_udividend", last_dividend, 32'hFFFF_FFFF);
        run_op(2'b11, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'd1, HIT_LAT);
        // special cases resolved without the divider
        run_op(2'b00, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
        run_op(2'b10, 32'd5, 32'd0, 5'd9, 32'd5, 1);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1);
        // negative divisor: quotient negative, remainder follows dividend
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 37);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd13, 32'd1, HIT_LAT);
        // zero dividend short-cut in the divider
        run_op(2'b00, 32'd0, 32'd5, 5'd14, 32'd0, 4);
        // INT_MIN magnitude stays 0x80000000
        run_op(2'b00, 32'h8000_0000, 32'd2, 5'd20, 32'hC000_0000, 37);
        check("mag_int_min", last_dividend, 32'h8000_0000);
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd18, 32'hFFFF_FFF2, 37);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd19, 32'hFFFF_FFFE, HIT_LAT);
        // DIV-then-REM idiom, then a signedness change
        run_op(2'b00, 32'd100, 32'd7, 5'd15, 32'd14, 37);
        run_op(2'b10, 32'd100, 32'd7, 5'd16, 32'd2, HIT_LAT);
        run_op(2'b01, 32'd100, 32'd7, 5'd17, 32'd14, 37);

        // flush in IDLE: request refused, and any cached result dropped
        @(negedge clk);
        l0        = load_cnt;
        req_op    = 2'b01;
        req_rs1   = 32'd9;
        req_rs2   = 32'd3;
        req_tag   = 5'd22;
        req_valid = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_idle_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("flush_idle_no_load", load_cnt, l0);
        run_op(2'b11, 32'd100, 32'd7, 5'd23, 32'd2, 37);

        // flush 10 cycles after div_load: no response, drain until div_resp
        @(negedge clk);
        req_op    = 2'b01;
        req_rs1   = 32'd1000;
        req_rs2   = 32'd3;
        req_tag   = 5'd7;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("flush_case_load", {31'd0, div_load}, 32'd1);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (div_resp) begin
                seen = 1'b1;
                break;
            end
            check("drain_ready_low", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        check("drain_saw_div_resp", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("drain_ready_back", {31'd0, req_ready}, 32'd1);
        run_op(2'b01, 32'd9, 32'd3, 5'd21, 32'd3, 37);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
